clause_cell_seq: RTL
====================

// Module: clause_cell_seq
// PURPOSE
//  Parametrised, sequential successor to the fixed-width literal trees: one clause of NUM_LITS literals.
//  Stores its own literals and evaluates them against the current variable values on request.
//  Reports clause-satisfied, conflict or unit (implication) status from registered outputs.
//  Unit results are handed to the BCP arbiter over a valid/ready handshake.
//  Sits in clause_array, one instance per clause row.
// PARAMETERS
//  NUM_LITS   8                    literals per clause; power of two, >= 2
//  IDX_W      $clog2(NUM_LITS)     width of literal index (derived, do not override)
// PORTS
//  clk              in   1            clock, rising edge
//  rst              in   1            asynchronous, active-high reset
//  wr_i             in   1            load lit_i into literal storage
//  lit_i            in   2*NUM_LITS   literal i at [2i+1:2i]: 00 absent, 10 positive, 01 negative
//  lit_o            out  2*NUM_LITS   stored literals (registered)
//  eval_i           in   1            start evaluation (single-cycle strobe)
//  var_value_i      in   3*NUM_LITS   slot i at [3i+2:3i]: bit2 implied flag, [1:0] 00 free, 10 true, 01 false
//  var_value_o      out  3*NUM_LITS   var_value_i passthrough, with implied slot overridden in IMPLY
//  busy_o           out  1            high in EVAL and IMPLY
//  clausesat_o      out  1            clause satisfied (registered)
//  cclause_o        out  1            conflict clause (registered)
//  freelitcnt_o     out  2            free-literal count, saturating: 0, 1, 2 (= two or more)
//  imp_valid_o      out  1            implication offer valid
//  imp_ready_i      in   1            arbiter accepts implication
//  imp_idx_o        out  IDX_W        index of the implied literal
//  imp_value_o      out  2            value to assign to the variable (= stored literal code)
// BEHAVIOUR
//  Reset (async): state IDLE; literal storage all 00; all outputs 0; var_value_o = var_value_i.
//  Literal i is satisfied when lit != 00 and var_value[1:0] == lit.
//  Literal i is free when lit != 00 and var_value[1:0] == 00.
//  IDLE:
//   - wr_i: storage <= lit_i; clears clausesat_o, cclause_o, freelitcnt_o.
//   - eval_i (no wr_i): capture var_value_i into a register; go to EVAL.
//  EVAL (one cycle): compute on the captured values, registering all results at the end of the cycle.
//   - any literal satisfied -> clausesat_o=1; go to IDLE.
//   - else free==0 -> cclause_o=1; go to IDLE. An empty clause (all 00) is a conflict.
//   - else free==1 -> imp_idx_o = the free slot, imp_value_o = its lit code, imp_valid_o=1; go to IMPLY.
//   - else (free>=2) -> go to IDLE; status only.
//   - freelitcnt_o is updated in every outcome.
//  Latency: eval_i sampled at edge N; results visible from cycle N+2.
//  IMPLY:
//   - imp_valid_o, imp_idx_o and imp_value_o stay stable until imp_ready_i is high at a rising edge.
//   - On that edge: imp_valid_o=0, freelitcnt_o=0, clausesat_o=1 (clause now satisfied by the implication); go to IDLE.
//   - While in IMPLY, var_value_o slot imp_idx_o = {1'b1, imp_value_o}; all other slots pass through.
//  Status outputs (clausesat_o, cclause_o, freelitcnt_o) hold until the next eval completes or a wr_i.
//  eval_i while busy_o=1: ignored, no queuing.
//  wr_i in any state: takes priority and aborts EVAL/IMPLY.
//   - imp_valid_o drops the next cycle without a handshake; storage reloads; flags clear; go to IDLE.
//  wr_i and eval_i in the same cycle: write only; eval dropped.
//  imp_ready_i while imp_valid_o=0: ignored.
//  Reset mid-IMPLY: offer withdrawn immediately (async); no handshake is implied.
// TESTING (NUM_LITS=8)
//  1. lit_i=16'h0006, var: slot0=3'b001, slot1=3'b000; eval -> N+2: imp_valid_o=1, imp_idx_o=1, imp_value_o=2'b01, freelitcnt_o=1.
//  2. Continue 1 with imp_ready_i low for 3 cycles, then high 1 cycle -> outputs stable 3 cycles; then imp_valid_o=0, clausesat_o=1, busy_o=0.
//  3. lit_i=16'h0006, slot0=3'b010 -> clausesat_o=1, imp_valid_o never asserts.
//  4. lit_i=16'h0000, eval -> cclause_o=1, freelitcnt_o=0; lit_i=16'h0006 with slot0=3'b001 and slot1=3'b010 -> cclause_o=1.
//  5. Three free literals -> freelitcnt_o=2, no flags; wr_i during IMPLY -> imp_valid_o=0 next cycle, state IDLE, eval_i during busy ignored.
//  6. Assert rst mid-IMPLY -> all outputs 0 asynchronously; lit_o=0 after release.

Source files
------------

// File: rtl/clause_cell_seq.sv
// One clause of NUM_LITS stored literals, evaluated on request against captured variable values.
// Reports satisfied / conflict / unit status and offers unit implications over valid/ready.
module clause_cell_seq #(
    parameter int unsigned NUM_LITS = 8,
    localparam int unsigned IDX_W = $clog2(NUM_LITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_i,
    input  logic [2*NUM_LITS-1:0]   lit_i,
    output logic [2*NUM_LITS-1:0]   lit_o,
    input  logic                    eval_i,
    input  logic [3*NUM_LITS-1:0]   var_value_i,
    output logic [3*NUM_LITS-1:0]   var_value_o,
    output logic                    busy_o,
    output logic                    clausesat_o,
    output logic                    cclause_o,
    output logic [1:0]              freelitcnt_o,
    output logic                    imp_valid_o,
    input  logic                    imp_ready_i,
    output logic [IDX_W-1:0]        imp_idx_o,
    output logic [1:0]              imp_value_o
);

    typedef enum logic [1:0] {StIdle, StEval, StImply} state_e;

    state_e                  state_q, state_d;
    logic [2*NUM_LITS-1:0]   lits_q, lits_d;
    logic [2*NUM_LITS-1:0]   vals_q, vals_d;   // captured value codes; implied flags not needed
    logic                    sat_q, sat_d;
    logic                    cc_q, cc_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    imp_valid_q, imp_valid_d;
    logic [IDX_W-1:0]        imp_idx_q, imp_idx_d;
    logic [1:0]              imp_value_q, imp_value_d;

    logic                    any_sat;
    logic [1:0]              free_cnt;
    logic [IDX_W-1:0]        free_idx;

    // Clause evaluation over the captured values
    always_comb begin
        any_sat  = 1'b0;
        free_cnt = 2'd0;
        free_idx = '0;
        for (int i = 0; i < int'(NUM_LITS); i++) begin
            if (lits_q[2*i +: 2] != 2'b00 && vals_q[2*i +: 2] == lits_q[2*i +: 2]) begin
                any_sat = 1'b1;
            end
            if (lits_q[2*i +: 2] != 2'b00 && vals_q[2*i +: 2] == 2'b00) begin
                if (free_cnt != 2'd2) free_cnt = free_cnt + 2'd1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lits_d      = lits_q;
        vals_d      = vals_q;
        sat_d       = sat_q;
        cc_d        = cc_q;
        cnt_d       = cnt_q;
        imp_valid_d = imp_valid_q;
        imp_idx_d   = imp_idx_q;
        imp_value_d = imp_value_q;
        if (wr_i) begin
            // A write aborts any evaluation or pending offer
            lits_d      = lit_i;
            sat_d       = 1'b0;
            cc_d        = 1'b0;
            cnt_d       = 2'd0;
            imp_valid_d = 1'b0;
            state_d     = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (eval_i) begin
                        for (int i = 0; i < int'(NUM_LITS); i++) begin
                            vals_d[2*i +: 2] = var_value_i[3*i +: 2];
                        end
                        state_d = StEval;
                    end
                end
                StEval: begin
                    sat_d   = any_sat;
                    cc_d    = !any_sat && free_cnt == 2'd0;
                    cnt_d   = free_cnt;
                    state_d = StIdle;
                    if (!any_sat && free_cnt == 2'd1) begin
                        imp_valid_d = 1'b1;
                        imp_idx_d   = free_idx;
                        imp_value_d = lits_q[2*int'(free_idx) +: 2];
                        state_d     = StImply;
                    end
                end
                StImply: begin
                    if (imp_ready_i) begin
                        imp_valid_d = 1'b0;
                        cnt_d       = 2'd0;
                        sat_d       = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lits_q      <= '0;
            vals_q      <= '0;
            sat_q       <= 1'b0;
            cc_q        <= 1'b0;
            cnt_q       <= 2'd0;
            imp_valid_q <= 1'b0;
            imp_idx_q   <= '0;
            imp_value_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            lits_q      <= lits_d;
            vals_q      <= vals_d;
            sat_q       <= sat_d;
            cc_q        <= cc_d;
            cnt_q       <= cnt_d;
            imp_valid_q <= imp_valid_d;
            imp_idx_q   <= imp_idx_d;
            imp_value_q <= imp_value_d;
        end
    end

    // While offering, show the implied assignment on its slot
    always_comb begin
        var_value_o = var_value_i;
        if (state_q == StImply) begin
            var_value_o[3*int'(imp_idx_q) +: 3] = {1'b1, imp_value_q};
        end
    end

    assign lit_o        = lits_q;
    assign busy_o       = state_q != StIdle;
    assign clausesat_o  = sat_q;
    assign cclause_o    = cc_q;
    assign freelitcnt_o = cnt_q;
    assign imp_valid_o  = imp_valid_q;
    assign imp_idx_o    = imp_idx_q;
    assign imp_value_o  = imp_value_q;

endmodule
